spdif_pop_sched: RTL and testbench



---
 rtl/spdif_pop_sched.sv | 166 ++++++++++++++++
 tb/tb_spdif_pop_sched.sv | 344 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spdif_pop_sched.sv
// spdif_pop_sched: round-robin read scheduler for the S/PDIF input FIFOs.
// Pops one word per grant, enforces L/R pairing and post-unlock muting.
module spdif_pop_sched #(
  parameter int NUM_IN      = 2,
  parameter int NUM_IN_LOG2 = 1,
  parameter int NUM_RATE    = 5,
  parameter int MUTE_WORDS  = 16
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_IN-1:0]              empty_i,
  input  logic [NUM_IN*24-1:0]           data_i,
  input  logic [NUM_IN-1:0]              lrck_i,
  input  logic [NUM_IN-1:0]              locked_i,
  input  logic [NUM_IN*NUM_RATE-1:0]     rate_i,
  input  logic                           ready_i,
  output logic [NUM_IN-1:0]              pop_o,
  output logic [2*NUM_IN-1:0]            ack_o,
  output logic [23:0]                    data_o,
  output logic [2*NUM_IN*NUM_RATE-1:0]   rate_o,
  output logic [7:0]                     drop_cnt_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    POP  = 2'd1,
    EMIT = 2'd2
  } state_t;

  state_t state, state_d;

  logic [NUM_IN_LOG2-1:0] rr_ptr;
  logic [NUM_IN_LOG2-1:0] g;
  logic [NUM_IN_LOG2-1:0] pick;
  logic [NUM_IN_LOG2-1:0] cand;
  logic                   hit;
  logic                   grant;

  logic [23:0]            word_q;
  logic [23:0]            last_q;
  logic                   lrck_q;

  logic [NUM_IN-1:0]      expect_l;
  logic [NUM_IN-1:0]      reload;
  logic [7:0]             mute_cnt [NUM_IN];
  logic [NUM_RATE-1:0]    rate_q   [NUM_IN];

  logic                   emit;
  logic                   muted;
  logic                   accept;
  logic                   mis;

  // first non-empty FIFO at or after rr_ptr, wrapping
  always_comb begin
    hit  = 1'b0;
    pick = rr_ptr;
    cand = rr_ptr;
    for (int k = NUM_IN - 1; k >= 0; k--) begin
      cand = NUM_IN_LOG2'((int'(rr_ptr) + k) % NUM_IN);
      if (!empty_i[cand]) begin
        hit  = 1'b1;
        pick = cand;
      end
    end
  end

  // lock loss or rate change restarts the mute window
  always_comb begin
    reload = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      reload[i] = !locked_i[i] ||
        (rate_i[i*NUM_RATE +: NUM_RATE] != rate_q[i]);
    end
  end

  assign grant  = (state == IDLE) && ready_i && hit;
  assign emit   = (state == EMIT);
  assign muted  = reload[g] || (mute_cnt[g] != 8'd0);
  assign accept = emit && !muted && (lrck_q == expect_l[g]);
  assign mis    = emit && !muted && (lrck_q != expect_l[g]);
  assign data_o = accept ? word_q : last_q;

  // state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_d;
  end

  // next state, pop strobe and channel ack
  always_comb begin
    state_d = state;
    pop_o   = '0;
    ack_o   = '0;
    unique case (state)
      IDLE: if (grant) state_d = POP;
      POP: begin
        pop_o[g] = 1'b1;
        state_d  = EMIT;
      end
      EMIT: begin
        if (accept) ack_o[{g, ~lrck_q}] = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // grant latch, pointer advance, held output word, drop counter
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      g          <= '0;
      rr_ptr     <= '0;
      word_q     <= '0;
      lrck_q     <= 1'b0;
      last_q     <= '0;
      drop_cnt_o <= '0;
    end else begin
      if (grant) begin
        g      <= pick;
        word_q <= data_i[pick*24 +: 24];
        lrck_q <= lrck_i[pick];
      end
      if (emit) begin
        rr_ptr <= (g == NUM_IN_LOG2'(NUM_IN - 1)) ? '0 : g + 1'b1;
      end
      if (accept) last_q <= word_q;
      if (mis && drop_cnt_o != 8'hFF) drop_cnt_o <= drop_cnt_o + 8'd1;
    end
  end

  // per-input mute window, pairing phase and rate capture
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_IN; i++) begin
        mute_cnt[i] <= 8'(MUTE_WORDS);
        rate_q[i]   <= '0;
        expect_l[i] <= 1'b1;
      end
    end else begin
      for (int i = 0; i < NUM_IN; i++) begin
        if (reload[i]) begin
          mute_cnt[i] <= 8'(MUTE_WORDS);
          rate_q[i]   <= rate_i[i*NUM_RATE +: NUM_RATE];
          expect_l[i] <= 1'b1;
        end else if (emit && g == NUM_IN_LOG2'(i)) begin
          if (mute_cnt[i] != 8'd0) begin
            mute_cnt[i] <= mute_cnt[i] - 8'd1;
            expect_l[i] <= 1'b1;
          end else if (lrck_q == expect_l[i]) begin
            expect_l[i] <= ~expect_l[i];
          end
        end
      end
    end
  end

  // rate code fanned out to both channels of each input
  always_comb begin
    rate_o = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      rate_o[(2*i)*NUM_RATE +: NUM_RATE]   = rate_q[i];
      rate_o[(2*i+1)*NUM_RATE +: NUM_RATE] = rate_q[i];
    end
  end

endmodule

// File: tb/tb_spdif_pop_sched.sv
// tb_spdif_pop_sched: directed bench for spdif_pop_sched.
// FIFO heads modelled with queues; acks and pops logged per cycle.
module tb_spdif_pop_sched;

  localparam int NI = 2;
  localparam int NR = 5;

  logic              clk = 1'b0;
  logic              rst;
  logic [NI-1:0]     empty_i;
  logic [NI*24-1:0]  data_i;
  logic [NI-1:0]     lrck_i;
  logic [NI-1:0]     locked_i;
  logic [NI*NR-1:0]  rate_i;
  logic              ready_i;
  logic [NI-1:0]     pop_o;
  logic [2*NI-1:0]   ack_o;
  logic [23:0]       data_o;
  logic [2*NI*NR-1:0] rate_o;
  logic [7:0]        drop_cnt_o;

  spdif_pop_sched dut (
    .clk        (clk),
    .rst        (rst),
    .empty_i    (empty_i),
    .data_i     (data_i),
    .lrck_i     (lrck_i),
    .locked_i   (locked_i),
    .rate_i     (rate_i),
    .ready_i    (ready_i),
    .pop_o      (pop_o),
    .ack_o      (ack_o),
    .data_o     (data_o),
    .rate_o     (rate_o),
    .drop_cnt_o (drop_cnt_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  typedef struct {
    logic        l;
    logic [23:0] d;
  } word_t;

  typedef struct {
    logic [3:0]  ack;
    logic [23:0] d;
    int          cyc;
  } ack_t;

  typedef struct {
    int idx;
    int cyc;
  } pop_t;

  typedef struct {
    int          idx;
    logic        l;
    logic [23:0] d;
    logic [3:0]  ack;
    logic [7:0]  drops;
  } vec_t;

  word_t fq0[$];
  word_t fq1[$];
  ack_t  ack_log[$];
  pop_t  pop_log[$];

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  function automatic void refresh();
    empty_i[0] = (fq0.size() == 0);
    empty_i[1] = (fq1.size() == 0);
    if (fq0.size() != 0) begin
      data_i[23:0] = fq0[0].d;
      lrck_i[0]    = fq0[0].l;
    end
    if (fq1.size() != 0) begin
      data_i[47:24] = fq1[0].d;
      lrck_i[1]     = fq1[0].l;
    end
  endfunction

  task automatic push(input int idx, input logic l, input logic [23:0] d);
    word_t w;
    w.l = l;
    w.d = d;
    if (idx == 0) fq0.push_back(w);
    else          fq1.push_back(w);
    refresh();
  endtask

  task automatic drain(input int lim);
    int n;
    n = 0;
    while ((fq0.size() != 0 || fq1.size() != 0) && n < lim) begin
      @(negedge clk);
      n++;
    end
    #1;
    n_cmp++;
    if (n >= lim) begin
      n_err++;
      $display("FAIL drain: fifos not empty after %0d clk", lim);
    end
    repeat (3) @(negedge clk);
    #1;
  endtask

  task automatic wait_pop(input int idx, input int lim);
    int n;
    n = 0;
    while (!pop_o[idx] && n < lim) begin
      @(negedge clk);
      #1;
      n++;
    end
    n_cmp++;
    if (!pop_o[idx]) begin
      n_err++;
      $display("FAIL wait_pop%0d: no pop within %0d clk", idx, lim);
    end
  endtask

  // FIFO model and output log, sampled on the falling edge
  always @(negedge clk) begin : mon
    ack_t a;
    pop_t p;
    if (rst && ack_o != '0) begin
      a = '{ack_o, data_o, cyc};
      ack_log.push_back(a);
      n_cmp++;
      if ($countones(ack_o) != 1) begin
        n_err++;
        $display("FAIL ack_onehot: got %b want one bit", ack_o);
      end
    end
    if (rst && pop_o != '0) begin
      n_cmp++;
      if ($countones(pop_o) != 1) begin
        n_err++;
        $display("FAIL pop_onehot: got %b want one bit", pop_o);
      end
      for (int i = 0; i < NI; i++) begin
        if (pop_o[i]) begin
          p = '{i, cyc};
          pop_log.push_back(p);
          if (i == 0 && fq0.size() != 0) void'(fq0.pop_front());
          if (i == 1 && fq1.size() != 0) void'(fq1.pop_front());
        end
      end
      refresh();
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1);
  end

  vec_t vt[8];

  initial begin
    vt[0] = '{0, 1'b1, 24'h123456, 4'b0001, 8'd0};
    vt[1] = '{0, 1'b0, 24'hABCDEF, 4'b0010, 8'd0};
    vt[2] = '{0, 1'b0, 24'h0F0F0F, 4'b0000, 8'd1};
    vt[3] = '{0, 1'b1, 24'h111111, 4'b0001, 8'd1};
    vt[4] = '{0, 1'b0, 24'h222222, 4'b0010, 8'd1};
    vt[5] = '{1, 1'b1, 24'h0000AA, 4'b0100, 8'd1};
    vt[6] = '{1, 1'b1, 24'h0000BB, 4'b0000, 8'd2};
    vt[7] = '{1, 1'b0, 24'h0000CC, 4'b1000, 8'd2};

    rst      = 1'b0;
    ready_i  = 1'b1;
    locked_i = '1;
    rate_i   = {5'b00100, 5'b00100};
    empty_i  = '1;
    data_i   = '0;
    lrck_i   = '0;

    repeat (2) @(negedge clk);
    #1;
    check("rst_pop", pop_o, 0);
    check("rst_ack", ack_o, 0);
    check("rst_data", data_o, 0);
    check("rst_rate", rate_o, 0);
    check("rst_drop", drop_cnt_o, 0);

    rst = 1'b1;
    repeat (100) @(negedge clk);
    #1;
    check("idle_pops", pop_log.size(), 0);
    check("idle_acks", ack_log.size(), 0);
    check("idle_rate", rate_o, {4{5'b00100}});

    // flush the post-reset mute window of both inputs
    for (int k = 0; k < 16; k++) begin
      push(0, (k % 2) == 0, 24'h0F0000 + 24'(k));
      push(1, (k % 2) == 0, 24'h0E0000 + 24'(k));
    end
    drain(300);
    check("unmute_acks", ack_log.size(), 0);
    check("unmute_pops", pop_log.size(), 32);
    check("unmute_drop", drop_cnt_o, 0);

    for (int v = 0; v < 8; v++) begin
      int c0;
      ack_log.delete();
      pop_log.delete();
      c0 = cyc;
      push(vt[v].idx, vt[v].l, vt[v].d);
      repeat (5) @(negedge clk);
      #1;
      check($sformatf("vec%0d_npop", v), pop_log.size(), 1);
      if (pop_log.size() == 1) begin
        check($sformatf("vec%0d_pidx", v), pop_log[0].idx, vt[v].idx);
        check($sformatf("vec%0d_plat", v), pop_log[0].cyc - c0, 1);
      end
      check($sformatf("vec%0d_nack", v), ack_log.size(),
            (vt[v].ack != 0) ? 1 : 0);
      if (ack_log.size() == 1 && vt[v].ack != 0) begin
        check($sformatf("vec%0d_ack", v), ack_log[0].ack, vt[v].ack);
        check($sformatf("vec%0d_data", v), ack_log[0].d, vt[v].d);
        check($sformatf("vec%0d_alat", v), ack_log[0].cyc - c0, 2);
      end
      check($sformatf("vec%0d_drop", v), drop_cnt_o, vt[v].drops);
    end

    // both inputs busy: strict alternation, one grant per 3 clk
    ack_log.delete();
    pop_log.delete();
    for (int w = 0; w < 4; w++) begin
      for (int i = 0; i < 2; i++) begin
        push(i, (w % 2) == 0, 24'hA00000 + 24'(i * 16 + w));
      end
    end
    drain(100);
    check("alt_npop", pop_log.size(), 8);
    check("alt_nack", ack_log.size(), 8);
    for (int k = 0; k < 8; k++) begin
      if (k < pop_log.size()) begin
        check($sformatf("alt%0d_pidx", k), pop_log[k].idx, k % 2);
        if (k > 0) begin
          check($sformatf("alt%0d_gap", k),
                pop_log[k].cyc - pop_log[k-1].cyc, 3);
        end
      end
      if (k < ack_log.size()) begin
        int i;
        int w;
        logic [3:0] ea;
        i  = k % 2;
        w  = k / 2;
        ea = 4'b0001 << (2 * i + (((w % 2) == 0) ? 0 : 1));
        check($sformatf("alt%0d_ack", k), ack_log[k].ack, ea);
        check($sformatf("alt%0d_data", k), ack_log[k].d,
              24'hA00000 + 24'(i * 16 + w));
      end
    end
    check("alt_drop", drop_cnt_o, 2);

    // rate change on input 0: new code visible next clk, 16 words muted
    rate_i[4:0] = 5'b01000;
    @(negedge clk);
    #1;
    check("rate_ch01", rate_o[9:0], {2{5'b01000}});
    check("rate_ch23", rate_o[19:10], {2{5'b00100}});
    ack_log.delete();
    pop_log.delete();
    for (int k = 0; k < 16; k++) push(0, 1'b0, 24'h300000 + 24'(k));
    push(0, 1'b1, 24'h3000FF);
    drain(200);
    check("rate_npop", pop_log.size(), 17);
    check("rate_nack", ack_log.size(), 1);
    if (ack_log.size() == 1) begin
      check("rate_ack", ack_log[0].ack, 4'b0001);
      check("rate_data", ack_log[0].d, 24'h3000FF);
    end
    check("rate_drop", drop_cnt_o, 2);

    // lock glitch on input 1 during its EMIT cycle
    ack_log.delete();
    pop_log.delete();
    push(0, 1'b0, 24'hC0FFEE);
    push(1, 1'b1, 24'h5A5A5A);
    wait_pop(1, 10);
    @(posedge clk);
    #1;
    locked_i[1] = 1'b0;
    @(posedge clk);
    #1;
    locked_i[1] = 1'b1;
    drain(50);
    check("lock_npop", pop_log.size(), 2);
    check("lock_nack", ack_log.size(), 1);
    if (ack_log.size() == 1) begin
      check("lock_ack", ack_log[0].ack, 4'b0010);
      check("lock_data", ack_log[0].d, 24'hC0FFEE);
    end
    ack_log.delete();
    pop_log.delete();
    for (int k = 0; k < 16; k++) push(1, 1'b1, 24'h400000 + 24'(k));
    push(1, 1'b1, 24'h171717);
    drain(200);
    check("relock_npop", pop_log.size(), 17);
    check("relock_nack", ack_log.size(), 1);
    if (ack_log.size() == 1) begin
      check("relock_ack", ack_log[0].ack, 4'b0100);
      check("relock_data", ack_log[0].d, 24'h171717);
    end
    check("relock_drop", drop_cnt_o, 2);

    // reset during POP clears the strobe immediately
    push(0, 1'b1, 24'h777777);
    wait_pop(0, 10);
    rst = 1'b0;
    #1;
    check("rstpop_pop", pop_o, 0);
    check("rstpop_ack", ack_o, 0);
    check("rstpop_data", data_o, 0);
    check("rstpop_drop", drop_cnt_o, 0);
    check("rstpop_rate", rate_o, 0);
    @(negedge clk);
    rst = 1'b1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
